instr_prefetch_buffer: RTL and testbench

INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

---
 rtl/instr_prefetch_buffer.sv | 212 +++++++++++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: issues word-aligned fetches ahead of the CPU,
// queues the returned instructions together with their byte addresses, and
// discards in-flight responses after a redirect.
//
// Optional feature: define PREFETCH_PARITY_EN to check the even-parity bit
// on each response. With it, a bad word sets a sticky parity_error and the
// fetcher parks in ERROR until the next redirect. Without it, bit 32 of the
// response is ignored and parity_error is tied low.

module instr_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [32:0] mem_rsp_data,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    output logic        parity_error
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [CW:0]   DEPTH_W    = (CW+1)'(DEPTH);
    localparam logic [31:0]   RESET_PC_W = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1
`ifdef PREFETCH_PARITY_EN
        ,
        S_ERROR = 2'd2
`endif
    } state_t;

    state_t        state_q;
    state_t        state_next;

    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;

    logic [CW-1:0] occ_q;
    logic [CW-1:0] outst_q;
    logic [CW-1:0] outst_next;
    logic [CW-1:0] discard_q;
    logic [CW-1:0] discard_next;
    logic [CW:0]   in_use;

    logic [31:0]   fetch_pc_q;
    logic [31:0]   rsp_pc_q;
    logic [31:0]   redirect_pc_w;

    logic          req_fire;
    logic          pop;
    logic          rsp_deliverable;
    logic          rsp_parity_bad;
    logic          push;

    logic [1:0]    unused_redirect_lsbs;

    assign redirect_pc_w        = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = redirect_pc[1:0];

    // Entries held plus entries already promised to in-flight requests.
    assign in_use = {1'b0, occ_q} + {1'b0, outst_q};

    assign mem_req_valid = rst_n && (state_q == S_RUN) && (in_use < DEPTH_W) && !redirect_valid;
    assign mem_req_addr  = fetch_pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign out_valid = (occ_q != '0);
    assign out_instr = out_valid ? fifo_instr[rd_ptr_q] : '0;
    assign out_pc    = out_valid ? fifo_pc[rd_ptr_q]    : '0;
    assign pop       = out_valid && out_ready;

    // A response reaches the FIFO only in RUN with nothing left to discard;
    // a response arriving alongside a redirect belongs to the old stream.
    assign rsp_deliverable = mem_rsp_valid && !redirect_valid
                             && (state_q == S_RUN) && (discard_q == '0);
    assign push            = rsp_deliverable && !rsp_parity_bad;

`ifdef PREFETCH_PARITY_EN
    logic perr_q;

    assign rsp_parity_bad = ^mem_rsp_data;
    assign parity_error   = perr_q;

    // Sticky parity fault flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else if (rsp_deliverable && rsp_parity_bad) begin
            perr_q <= 1'b1;
        end
    end
`else
    logic unused_rsp_parity;

    assign unused_rsp_parity = mem_rsp_data[32];
    assign rsp_parity_bad    = 1'b0;
    assign parity_error      = 1'b0;
`endif

    // In-flight and discard counters for the next cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned, which would infer a latch.
        outst_next   = outst_q;
        discard_next = discard_q;
        if (req_fire && !mem_rsp_valid) begin
            outst_next = outst_q + CNT_ONE;
        end else if (!req_fire && mem_rsp_valid) begin
            outst_next = outst_q - CNT_ONE;
        end
        if (redirect_valid) begin
            discard_next = outst_next;
        end else if (mem_rsp_valid && (discard_q != '0)) begin
            discard_next = discard_q - CNT_ONE;
        end
    end

    // Next-state logic: redirect wins from any state.
    always_comb begin
        state_next = state_q;
        if (redirect_valid) begin
            state_next = (outst_next != '0) ? S_DRAIN : S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
`ifdef PREFETCH_PARITY_EN
                    if (rsp_deliverable && rsp_parity_bad) begin
                        state_next = S_ERROR;
                    end
`endif
                end
                S_DRAIN: begin
                    if (discard_next == '0) begin
                        state_next = S_RUN;
                    end
                end
`ifdef PREFETCH_PARITY_EN
                S_ERROR: state_next = S_ERROR;
`endif
                default: state_next = S_RUN;
            endcase
        end
    end

    // State register and fetch/queue bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
            state_q    <= S_RUN;
            fetch_pc_q <= RESET_PC_W;
            rsp_pc_q   <= RESET_PC_W;
            occ_q      <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q   <= state_next;
            outst_q   <= outst_next;
            discard_q <= discard_next;
            if (redirect_valid) begin
                fetch_pc_q <= redirect_pc_w;
                rsp_pc_q   <= redirect_pc_w;
                occ_q      <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                end
                if (push) begin
                    rsp_pc_q <= rsp_pc_q + 32'd4;
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                end
                if (push && !pop) begin
                    occ_q <= occ_q + CNT_ONE;
                end else if (!push && pop) begin
                    occ_q <= occ_q - CNT_ONE;
                end
            end
        end
    end

    // FIFO storage write; responses return in order, so rsp_pc_q tags each word.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the head outputs are gated by occupancy so stale contents never escape.
        if (push) begin
            fifo_instr[wr_ptr_q] <= mem_rsp_data[31:0];
            fifo_pc[wr_ptr_q]    <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Self-checking bench for instr_prefetch_buffer: directed scenarios with
// literal expectations, then randomized traffic compared every cycle against
// a queue-based behavioural model.

module tb_instr_prefetch_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [32:0] mem_rsp_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        parity_error;

    always #5 clk = ~clk;

    instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .parity_error   (parity_error)
    );

    // Behavioural model: requests in flight (stale ones belong to a flushed
    // stream), the delivered-but-unconsumed queue, and the fetch pointer.
    typedef struct packed { logic [31:0] addr; bit stale; } req_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;

    req_t        inflight[$];
    ent_t        fifo_m[$];
    logic [31:0] m_fetch_pc;
    bit          m_error;
    bit          m_perr;

    int checks = 0;
    int errors = 0;

    int p_mem_ready, p_rsp, p_out_ready, p_redirect, p_corrupt;
    int corrupt_at, rsp_count;
    bit force_redirect;
    logic [31:0] force_redirect_pc;

    logic [31:0] acc_log[$];
    logic [31:0] dlv_log[$];
    bit last_req_valid, last_out_valid, last_perr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic bit has_stale();
        foreach (inflight[i]) if (inflight[i].stale) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    // Starts and ends at a falling edge; drives inputs, compares against the
    // model, then advances the model across the rising edge.
    task automatic run_cycle();
        bit          rsp, bad, exp_rv, accept, pop, redir;
        logic [31:0] w;
        req_t        r;
        redir = force_redirect || ($urandom_range(99) < p_redirect);
        redirect_valid = redir;
        if (force_redirect) redirect_pc = force_redirect_pc;
        else if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | $urandom_range(15);
        else redirect_pc = $urandom_range(1023);
        mem_req_ready = ($urandom_range(99) < p_mem_ready);
        out_ready     = ($urandom_range(99) < p_out_ready);
        rsp = (inflight.size() > 0) && ($urandom_range(99) < p_rsp);
        bad = 1'b0;
        w   = '0;
        if (rsp) begin
            w   = word_of(inflight[0].addr);
            bad = (rsp_count == corrupt_at) || ($urandom_range(99) < p_corrupt);
            rsp_count++;
        end
        mem_rsp_valid = rsp;
        mem_rsp_data  = {(^w) ^ bad, w};
        #1;
        exp_rv = !m_error && !has_stale() && (fifo_m.size() + inflight.size() < DEPTH) && !redir;
        check("mem_req_valid", mem_req_valid, exp_rv);
        if (exp_rv) check("mem_req_addr", mem_req_addr, m_fetch_pc);
        check("out_valid", out_valid, fifo_m.size() != 0);
        if (fifo_m.size() != 0) begin
            check("out_pc", out_pc, fifo_m[0].pc);
            check("out_instr", out_instr, fifo_m[0].instr);
        end
        check("parity_error", parity_error, m_perr);
        last_req_valid = mem_req_valid;
        last_out_valid = out_valid;
        last_perr      = parity_error;
        if (mem_req_valid && mem_req_ready) acc_log.push_back(mem_req_addr);
        if (out_valid && out_ready) dlv_log.push_back(out_pc);
        accept = exp_rv && mem_req_ready;
        pop    = (fifo_m.size() != 0) && out_ready;
        @(posedge clk);
        if (redir) fifo_m.delete();
        else if (pop) void'(fifo_m.pop_front());
        if (rsp) begin
            r = inflight.pop_front();
            if (!redir && !r.stale && !m_error) begin
`ifdef PREFETCH_PARITY_EN
                if (bad) begin
                    m_error = 1'b1;
                    m_perr  = 1'b1;
                end else begin
                    fifo_m.push_back('{pc: r.addr, instr: w});
                end
`else
                fifo_m.push_back('{pc: r.addr, instr: w});
`endif
            end
        end
        if (redir) begin
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            m_error    = 1'b0;
            m_fetch_pc = {redirect_pc[31:2], 2'b00};
        end else if (accept) begin
            inflight.push_back('{addr: m_fetch_pc, stale: 1'b0});
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        @(negedge clk);
    endtask

    // Asserts reset (asynchronously, mid-cycle), checks the reset values at
    // once, and releases on a falling edge so the next cycle is the first.
    task automatic do_reset(input int cycles);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        out_ready      = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_mem_req_valid", mem_req_valid, 32'd0);
        check("rst_parity_error", parity_error, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        inflight.delete();
        fifo_m.delete();
        acc_log.delete();
        dlv_log.delete();
        m_fetch_pc     = 32'h0;
        m_error        = 1'b0;
        m_perr         = 1'b0;
        rsp_count      = 0;
        corrupt_at     = -1;
        force_redirect = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        force_redirect_pc = '0;
        p_redirect = 0;
        p_corrupt  = 0;

        // Streaming: one request and one delivery per cycle after fill.
        do_reset(3);
        p_mem_ready = 100; p_rsp = 100; p_out_ready = 100;
        repeat (10) run_cycle();
        check("t1_acc_cnt", acc_log.size(), 32'd10);
        check("t1_dlv_cnt", dlv_log.size(), 32'd8);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_acc[%0d]", i), q_at(acc_log, i), 32'(4 * i));
            check($sformatf("t1_dlv[%0d]", i), q_at(dlv_log, i), 32'(4 * i));
        end

        // Consumer stalled: exactly DEPTH requests, then resume at 16.
        do_reset(2);
        p_mem_ready = 100; p_rsp = 100; p_out_ready = 0;
        repeat (10) run_cycle();
        check("t2_acc_cnt", acc_log.size(), 32'd4);
        check("t2_stall", last_req_valid, 32'd0);
        for (int i = 0; i < 4; i++) check($sformatf("t2_acc[%0d]", i), q_at(acc_log, i), 32'(4 * i));
        p_out_ready = 100;
        repeat (8) run_cycle();
        check("t2_resume_addr", q_at(acc_log, 4), 32'd16);
        for (int i = 0; i < 6; i++) check($sformatf("t2_dlv[%0d]", i), q_at(dlv_log, i), 32'(4 * i));

        // Redirect with two requests outstanding; low address bits ignored.
        do_reset(2);
        p_mem_ready = 100; p_out_ready = 0;
        p_rsp = 0;   run_cycle();
        p_rsp = 100; run_cycle(); run_cycle();
        p_rsp = 0;   run_cycle();
        check("t3_acc_before", acc_log.size(), 32'd4);
        force_redirect = 1'b1; force_redirect_pc = 32'h0000_004A;
        run_cycle();
        force_redirect = 1'b0;
        p_rsp = 100; p_out_ready = 100;
        run_cycle();
        check("t3_out_valid_low", last_out_valid, 32'd0);
        repeat (8) run_cycle();
        check("t3_first_req", q_at(acc_log, 4), 32'h48);
        check("t3_first_dlv", q_at(dlv_log, 0), 32'h48);

        // Third response carries a flipped parity bit.
        do_reset(2);
        p_mem_ready = 100; p_rsp = 100; p_out_ready = 100;
        corrupt_at = 2;
        repeat (8) run_cycle();
`ifdef PREFETCH_PARITY_EN
        check("t4_dlv_cnt", dlv_log.size(), 32'd2);
        check("t4_dlv0", q_at(dlv_log, 0), 32'd0);
        check("t4_dlv1", q_at(dlv_log, 1), 32'd4);
        check("t4_acc_cnt", acc_log.size(), 32'd4);
        check("t4_perr", last_perr, 32'd1);
        force_redirect = 1'b1; force_redirect_pc = 32'h0;
        run_cycle();
        force_redirect = 1'b0;
        repeat (4) run_cycle();
        check("t4_resume_addr", q_at(acc_log, 4), 32'd0);
        check("t4_perr_sticky", last_perr, 32'd1);
`else
        for (int i = 0; i < 3; i++) check($sformatf("t4_dlv[%0d]", i), q_at(dlv_log, i), 32'(4 * i));
        check("t4_perr", last_perr, 32'd0);
`endif

        // Randomized traffic, with one reset dropped in mid-stream.
        do_reset(2);
        for (int blk = 0; blk < 6; blk++) begin
            p_mem_ready = $urandom_range(30, 100);
            p_rsp       = $urandom_range(30, 100);
            p_out_ready = $urandom_range(20, 100);
            p_redirect  = $urandom_range(0, 4);
            p_corrupt   = $urandom_range(0, 2);
            if (blk == 3) do_reset(1);
            repeat (500) run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
